seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
// - Output-side counterpart to input conditioning: drives a 4-digit, common-anode, multiplexed 7-segment display.
// - Use: pedestrian/phase countdown readout of the traffic intersection controller.
// - Accepts a binary value (0..9999) via a load strobe.
// - Converts the value to BCD with an iterative double-dabble engine.
// - Time-multiplexes the four digits at a programmable refresh rate.
// PARAMETERS
// - REFRESH_DIV  100000  clk cycles each digit stays lit. Legal range: >=2. Counter width = $clog2(REFRESH_DIV).
// PORTS
// - clk      in   1   system clock; all state on posedge
// - rst_n    in   1   asynchronous, active-low reset
// - load     in   1   1-cycle strobe; capture value when not busy
// - value    in   14  binary number to display; values >9999 are clamped
// - dp_en    in   4   decimal point enable per digit, active-high; bit0 = rightmost digit
// - busy     out  1   conversion in progress; load ignored while high
// - seg      out  7   {g,f,e,d,c,b,a}, active-low
// - dp       out  1   decimal point, active-low
// - an       out  4   digit enables, active-low, one-hot-low; an[0] = rightmost digit
// BEHAVIOUR
// - Reset values: seg=7'h7F, dp=1, an=4'hF, busy=0, displayed digits=0000, digit index=0, refresh counter=0.
// - Conversion FSM states: IDLE, SHIFT.
//   - IDLE: load=1 at edge N -> capture min(value,9999), clear BCD scratch, go SHIFT; busy=1 from edge N.
//   - SHIFT: 14 iterations, one per clk (edges N+1..N+14).
//     - Each iteration: add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1.
//   - On edge N+14: copy the 4 BCD nibbles into the display register in one step (atomic; no partially updated digit is ever shown), busy=0, return to IDLE.
//   - load while busy: ignored. No queueing and no restart.
//   - load in the same cycle busy falls (edge N+14): ignored. A new load is accepted from the edge N+15 onward.
// - Scan:
//   - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
//   - At terminal count: digit index += 1 mod 4 (3 -> 0).
//   - an, seg and dp are registered from the index and display register.
//   - First edge after reset release: an=4'b1110, showing digit 0.
//   - Exactly one an bit is low outside reset. Scan never pauses, including during conversion.
// - Segment code (seg, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
// - dp = ~dp_en[index], registered alongside seg.
// - Reset mid-conversion: returns to IDLE and clears the display to 0000. The partial result is discarded.
// - Clamp: value in 10000..16383 is displayed as 9999.
// CONFIGURATION
// - Macro SEG7_LEADING_BLANK_EN.
//   - Defined: leading-zero digits show seg=7'h7F. Digit 0 is never blanked; value 0 shows "   0". Example: 42 shows "  42". an still scans all four digits. dp follows dp_en even on blanked digits.
//   - Undefined: all four digits always show their numeral; 42 shows "0042".
// TESTING (REFRESH_DIV=4 in bench)
// - Reset held 3 cycles, then released -> seg=7F, an=F during reset; an=E at the first edge after release; busy=0.
// - load value=1234 -> busy high 14 cycles; next scan shows an=E/seg=19, D/30, B/24, 7/79, each for 4 cycles.
// - load 16383 -> display 9999 (seg=10 on all digits). Also load 0 -> 0000 (or "   0" with SEG7_LEADING_BLANK_EN).
// - load 1234, then load 5678 at cycle N+5 -> second load ignored; display 1234; busy falls at N+14.
// - Assert rst_n=0 at cycle N+7 of a 9999 conversion -> display 0000, busy=0, FSM IDLE. A fresh load 77 then converts correctly.
// - dp_en=4'b0100 with value 1250 -> dp=0 only while an=B; with SEG7_LEADING_BLANK_EN value 42 -> seg=7F on an=7 and an=B.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Drives a 4-digit, common-anode, multiplexed 7-segment display. A binary
// value (0..9999, larger values clamp to 9999) is captured on a load strobe
// and converted to BCD by an iterative double-dabble engine (one bit per
// clock, 14 clocks). The finished BCD result is copied into the display
// register in one step. The four digits are scanned continuously, each lit
// for REFRESH_DIV clocks.
//
// Ports:
//   clk     system clock, all state on posedge
//   rst_n   asynchronous active-low reset
//   load    1-cycle strobe, value captured when not busy
//   value   14-bit binary value to display
//   dp_en   per-digit decimal point enable (bit0 = rightmost digit)
//   busy    conversion in progress; load ignored while high
//   seg     {g,f,e,d,c,b,a}, active-low
//   dp      decimal point, active-low
//   an      digit enables, active-low one-hot; an[0] = rightmost digit
//
// Configuration macro: SEG7_LEADING_BLANK_EN
//   defined   -> leading-zero digits are blanked (digit 0 never blanked)
//   undefined -> all four numerals always shown
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [13:0] value,
  input  logic [3:0]  dp_en,
  output logic        busy,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [13:0]      bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [3:0]       iter_q, iter_d;
  logic [3:0][3:0]  disp_q, disp_d;
  logic [15:0]      adj;

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [3:0]       digit;
  logic [6:0]       seg_d;
  logic             blank;

  // Add 3 to every BCD nibble that is 5 or more (double-dabble correction).
  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      disp_q  <= disp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    disp_d  = disp_q;
    adj     = add3(bcd_q);
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          bin_d   = (value > 14'd9999) ? 14'd9999 : value;
          bcd_d   = '0;
          iter_d  = '0;
        end
      end
      SHIFT: begin
        bcd_d  = {adj[14:0], bin_q[13]};
        bin_d  = {bin_q[12:0], 1'b0};
        iter_d = iter_q + 4'd1;
        // The 14th iteration's result goes straight into the display
        // register, so the display never shows a half-converted value.
        if (iter_q == 4'd13) begin
          state_d = IDLE;
          disp_d  = {adj[14:0], bin_q[13]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);

  // ---------------- digit scan ----------------
  assign digit = disp_q[idx_q];

`ifdef SEG7_LEADING_BLANK_EN
  // Digit k (k>0) is a leading zero when it and every digit above it are 0.
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd3: blank = (disp_q[3] == 4'd0);
      2'd2: blank = (disp_q[3] == 4'd0) && (disp_q[2] == 4'd0);
      2'd1: blank = (disp_q[3] == 4'd0) && (disp_q[2] == 4'd0) && (disp_q[1] == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_d = 7'h7F;
    case (digit)
      4'd0: seg_d = 7'h40;
      4'd1: seg_d = 7'h79;
      4'd2: seg_d = 7'h24;
      4'd3: seg_d = 7'h30;
      4'd4: seg_d = 7'h19;
      4'd5: seg_d = 7'h12;
      4'd6: seg_d = 7'h02;
      4'd7: seg_d = 7'h78;
      4'd8: seg_d = 7'h00;
      4'd9: seg_d = 7'h10;
      default: seg_d = 7'h7F;
    endcase
    if (blank) seg_d = 7'h7F;
  end

  // Outputs are registered from the current index, so they trail an index
  // change by one clock; each digit still stays lit for REFRESH_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      an    <= '1;
      seg   <= '1;
      dp    <= 1'b1;
    end else begin
      if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      an  <= ~(4'b0001 << idx_q);
      seg <= seg_d;
      dp  <= ~dp_en[idx_q];
    end
  end

endmodule
